// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects two operands and an operator from key presses,
// launches one ALU operation, and reports the result or an error state.
module calc_sequencer #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_trig,
  input  logic [3:0]   key_value,
  input  logic [N-1:0] operand_in,
  input  logic         operand_valid,
  output logic         iu_clear,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [N-1:0] alu_result,
  input  logic         alu_ovf,
  output logic [N-1:0] result,
  output logic         result_valid,
  output logic         error,
  output logic [2:0]   state
);

  localparam logic [2:0] S_ENTER_A = 3'd0;
  localparam logic [2:0] S_ENTER_B = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_SHOW    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]   r_state;
  logic [N-1:0] r_op_a;
  logic [N-1:0] r_op_b;
  logic [N-1:0] r_result;
  logic [1:0]   r_alu_op;
  logic         r_alu_start;
  logic         r_iu_clear;
  logic [CW-1:0] r_cnt;

  logic         w_digit;
  logic         w_oper;
  logic         w_equals;
  logic         w_clear;
  logic [3:0]   w_code_full;
  logic [1:0]   w_op_code;
  logic         w_div_by_zero;

  assign w_digit     = key_trig && (key_value <= 4'd9);
  assign w_oper      = key_trig && (key_value >= 4'd10) && (key_value <= 4'd13);
  assign w_clear     = key_trig && (key_value == 4'd14);
  assign w_equals    = key_trig && (key_value == 4'd15);
  assign w_code_full = key_value - 4'd10;
  assign w_op_code   = w_code_full[1:0];
  assign w_div_by_zero = (r_alu_op == OP_DIV) && (operand_in == '0);

  // ALU handshake: alu_start is a single-cycle pulse, high exactly while in EXEC;
  // alu_done is a single-cycle pulse that carries alu_result/alu_ovf and is only
  // honoured in WAIT, so late or stray completions are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_ENTER_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_result    <= '0;
      r_alu_op    <= 2'd0;
      r_alu_start <= 1'b0;
      r_iu_clear  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_alu_start <= 1'b0;
      r_iu_clear  <= 1'b0;
      // Clear wins over everything, including a completion or timeout in WAIT.
      if (w_clear) begin
        r_iu_clear <= 1'b1;
        r_state    <= S_ENTER_A;
      end else begin
        case (r_state)
          S_ENTER_A: begin
            if (w_oper) begin
              if (operand_valid) begin
                r_op_a     <= operand_in;
                r_alu_op   <= w_op_code;
                r_iu_clear <= 1'b1;
                r_state    <= S_ENTER_B;
              end else begin
                r_state <= S_ERR;
              end
            end
          end
          S_ENTER_B: begin
            if (w_oper) begin
              r_alu_op <= w_op_code;
            end else if (w_equals) begin
              if (!operand_valid || w_div_by_zero) begin
                r_state <= S_ERR;
              end else begin
                r_op_b      <= operand_in;
                r_alu_start <= 1'b1;
                r_state     <= S_EXEC;
              end
            end
          end
          S_EXEC: begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (alu_done) begin
              r_result <= alu_result;
              r_state  <= alu_ovf ? S_ERR : S_SHOW;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_ERR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SHOW: begin
            if (w_digit) begin
              r_iu_clear <= 1'b1;
              r_state    <= S_ENTER_A;
            end else if (w_oper) begin
              r_op_a     <= r_result;
              r_alu_op   <= w_op_code;
              r_iu_clear <= 1'b1;
              r_state    <= S_ENTER_B;
            end
          end
          S_ERR: begin
            r_state <= S_ERR;
          end
          default: begin
            r_state <= S_ENTER_A;
          end
        endcase
      end
    end
  end

  assign state        = r_state;
  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign result       = r_result;
  assign alu_op       = r_alu_op;
  assign alu_start    = r_alu_start;
  assign iu_clear     = r_iu_clear;
  assign result_valid = (r_state == S_SHOW);
  assign error        = (r_state == S_ERR);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: behavioural ALU responder, expected-result queue,
// and immediate-assertion checks after each step.
module tb_calc_sequencer;

  localparam int N       = 8;
  localparam int TIMEOUT = 16;
  localparam int W       = N + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_trig = 1'b0;
  logic [3:0]   key_value = 4'd0;
  logic [N-1:0] operand_in = '0;
  logic         operand_valid = 1'b0;
  logic         iu_clear;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [1:0]   alu_op;
  logic         alu_start;
  logic         alu_done;
  logic [N-1:0] alu_result;
  logic         alu_ovf;
  logic [N-1:0] result;
  logic         result_valid;
  logic         error;
  logic [2:0]   state;

  int n_pass  = 0;
  int n_total = 0;
  int n_start = 0;
  logic [W-1:0] exp_q[$];

  logic         alu_hold  = 1'b0;
  logic         ovf_next  = 1'b0;
  logic         force_req = 1'b0;
  logic [N-1:0] force_val = '0;
  int           alu_lat   = 2;
  int           lat_cnt   = 0;
  logic         pend      = 1'b0;

  calc_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .key_trig(key_trig), .key_value(key_value),
    .operand_in(operand_in), .operand_valid(operand_valid), .iu_clear(iu_clear),
    .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .result(result), .result_valid(result_valid), .error(error), .state(state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [N-1:0] alu_fn(input logic signed [N-1:0] a,
                                          input logic signed [N-1:0] b,
                                          input logic [1:0] op);
    logic signed [N-1:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = (b == 0) ? '0 : a / b;
    endcase
    return r;
  endfunction

  // Behavioural ALU: answers each alu_start after alu_lat idle cycles unless held.
  always @(negedge clk) begin
    alu_done = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_start) begin
      n_start++;
      if (!alu_hold) begin
        pend    = 1'b1;
        lat_cnt = alu_lat;
      end
    end else if (pend) begin
      if (lat_cnt == 0) begin
        alu_done   = 1'b1;
        alu_ovf    = ovf_next;
        alu_result = alu_fn(op_a, op_b, alu_op);
        pend       = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
    if (force_req) begin
      alu_done   = 1'b1;
      alu_result = force_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k, input logic [N-1:0] v, input logic vld);
    key_trig      = 1'b1;
    key_value     = k;
    operand_in    = v;
    operand_valid = vld;
    tick();
    key_trig      = 1'b0;
    operand_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int cyc;
    logic [W-1:0] e;
    cyc = 0;
    while (!(result_valid || error) && cyc < 64) begin
      tick();
      cyc++;
    end
    if (!(result_valid || error)) begin
      chk({tag, "_timeout"}, 32'(result_valid || error), 32'd1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {23'd0, error, result}, {23'd0, e});
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_ops"}, {8'd0, op_a, op_b, result}, 32'd0);
    chk({tag, "_ctl"}, 32'({alu_op, alu_start, iu_clear, result_valid, error}), 32'd0);
  endtask

  initial begin
    int n0;
    int cyc;

    // Reset
    reset = 1'b0;
    repeat (3) tick();
    chk_reset_values("rst");
    reset = 1'b1;
    tick();

    // Completion outside WAIT is ignored
    force_val = 8'h55;
    force_req = 1'b1;
    tick();
    force_req = 1'b0;
    tick();
    chk("stray_done_state", 32'(state), 32'd0);
    chk("stray_done_result", 32'(result), 32'd0);

    // 12 + 5 = 17
    press(4'd10, 8'd12, 1'b1);
    chk("add_a_state", 32'(state), 32'd1);
    chk("add_op_a", 32'(op_a), 32'd12);
    chk("add_alu_op", 32'(alu_op), 32'd0);
    chk("add_iu_clear", 32'(iu_clear), 32'd1);
    tick();
    chk("add_iu_clear_pulse", 32'(iu_clear), 32'd0);
    n0 = n_start;
    exp_q.push_back({1'b0, 8'd17});
    press(4'd15, 8'd5, 1'b1);
    chk("add_exec_state", 32'(state), 32'd2);
    chk("add_op_b", 32'(op_b), 32'd5);
    chk("add_alu_start", 32'(alu_start), 32'd1);
    tick();
    chk("add_alu_start_pulse", 32'(alu_start), 32'd0);
    wait_result("add_result");
    chk("add_result_valid", 32'(result_valid), 32'd1);
    chk("add_start_count", 32'(n_start - n0), 32'd1);

    // Equals in SHOW holds the result
    press(4'd15, 8'd0, 1'b0);
    chk("show_eq_state", 32'(state), 32'd4);

    // Chain: 17 - 20 = -3
    press(4'd11, 8'd0, 1'b0);
    chk("chain_op_a", 32'(op_a), 32'd17);
    chk("chain_alu_op", 32'(alu_op), 32'd1);
    chk("chain_iu_clear", 32'(iu_clear), 32'd1);
    exp_q.push_back({1'b0, 8'hFD});
    press(4'd15, 8'd20, 1'b1);
    wait_result("sub_chain");

    // Chain again with overflow flagged: -3 * 20 -> 0xC4 latched, error
    press(4'd12, 8'd0, 1'b0);
    chk("ovf_op_a", 32'(op_a), 32'hFD);
    ovf_next = 1'b1;
    exp_q.push_back({1'b1, 8'hC4});
    press(4'd15, 8'd20, 1'b1);
    wait_result("mul_ovf");
    ovf_next = 1'b0;
    chk("ovf_state", 32'(state), 32'd5);
    chk("ovf_result_valid", 32'(result_valid), 32'd0);

    // ERR ignores everything but clear
    press(4'd10, 8'd1, 1'b1);
    press(4'd3, 8'd1, 1'b1);
    press(4'd15, 8'd1, 1'b1);
    chk("err_hold_state", 32'(state), 32'd5);
    press(4'd14, 8'd0, 1'b0);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_iu_clear", 32'(iu_clear), 32'd1);
    chk("clr_error", 32'(error), 32'd0);
    chk("clr_retain", {8'd0, op_a, op_b, result}, {8'd0, 8'hFD, 8'd20, 8'hC4});

    // -3 div then replaced by mul, * 4 = -12
    press(4'd13, 8'hFD, 1'b1);
    chk("repl_alu_op_div", 32'(alu_op), 32'd3);
    press(4'd12, 8'd0, 1'b0);
    chk("repl_alu_op_mul", 32'(alu_op), 32'd2);
    chk("repl_no_clear", 32'(iu_clear), 32'd0);
    chk("repl_state", 32'(state), 32'd1);
    exp_q.push_back({1'b0, 8'hF4});
    press(4'd15, 8'd4, 1'b1);
    wait_result("mul_neg");

    // Digit in SHOW starts a fresh entry
    press(4'd5, 8'd0, 1'b0);
    chk("show_digit_state", 32'(state), 32'd0);
    chk("show_digit_clear", 32'(iu_clear), 32'd1);

    // Divide by zero never starts the ALU
    press(4'd13, 8'd7, 1'b1);
    n0 = n_start;
    press(4'd15, 8'd0, 1'b1);
    chk("div0_error", 32'(error), 32'd1);
    repeat (3) tick();
    chk("div0_no_start", 32'(n_start - n0), 32'd0);
    press(4'd14, 8'd0, 1'b0);
    chk("div0_clr_state", 32'(state), 32'd0);
    chk("div0_clr_pulse", 32'(iu_clear), 32'd1);

    // Equals in ENTER_A is a no-op; operator without a valid operand errors
    press(4'd15, 8'd3, 1'b1);
    chk("a_eq_state", 32'(state), 32'd0);
    press(4'd10, 8'd3, 1'b0);
    chk("a_invalid_state", 32'(state), 32'd5);
    press(4'd14, 8'd0, 1'b0);

    // Timeout: ERR exactly TIMEOUT cycles after entering WAIT
    alu_hold = 1'b1;
    press(4'd10, 8'd1, 1'b1);
    press(4'd15, 8'd2, 1'b1);
    tick();
    chk("to_wait_state", 32'(state), 32'd3);
    cyc = 0;
    while (state != 3'd5 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("to_cycles", 32'(cyc), 32'(TIMEOUT));
    chk("to_result_kept", 32'(result), 32'hF4);
    press(4'd14, 8'd0, 1'b0);

    // Clear beats a simultaneous completion in WAIT
    press(4'd10, 8'd1, 1'b1);
    press(4'd15, 8'd1, 1'b1);
    tick();
    force_val = 8'h77;
    force_req = 1'b1;
    press(4'd14, 8'd0, 1'b0);
    force_req = 1'b0;
    chk("clr_vs_done_state", 32'(state), 32'd0);
    chk("clr_vs_done_result", 32'(result), 32'hF4);
    tick();

    // Reset in WAIT, then a late completion
    press(4'd10, 8'd3, 1'b1);
    press(4'd15, 8'd4, 1'b1);
    tick();
    chk("rw_wait_state", 32'(state), 32'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    force_val = 8'h99;
    force_req = 1'b1;
    tick();
    force_req = 1'b0;
    tick();
    chk_reset_values("rst_wait");
    alu_hold = 1'b0;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter N, default 8: operand/result width, two's complement.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for alu_done.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 key_trig  input  1  one-cycle pulse per key press; key_value valid in the same cycle.
REQ-006 key_value  input  4  key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 clear (*), 15 equals (#).
REQ-007 operand_in  input  N  two's-complement operand from the input unit.
REQ-008 operand_valid  input  1  input-unit validity flag for operand_in.
REQ-009 iu_clear  output  1  one-cycle pulse that clears the input-unit digit buffer.
REQ-010 op_a, op_b  output  N each  registered ALU operands.
REQ-011 alu_op  output  2  registered opcode: 0 add, 1 sub, 2 mul, 3 div.
REQ-012 alu_start  output  1  one-cycle ALU start pulse.
REQ-013 alu_done  input  1  ALU completion pulse.
REQ-014 alu_result  input  N  ALU result; valid when alu_done=1.
REQ-015 alu_ovf  input  1  ALU overflow flag; valid when alu_done=1.
REQ-016 result  output  N  latched final result.
REQ-017 result_valid  output  1  high while in SHOW.
REQ-018 error  output  1  high while in ERR.
REQ-019 state  output  3  FSM state: 0 ENTER_A, 1 ENTER_B, 2 EXEC, 3 WAIT, 4 SHOW, 5 ERR.

Function
REQ-020 Keys are acted on only in the key_trig cycle; operand_in/operand_valid are sampled in that same cycle. Digit keys are ignored by this block except where stated.
REQ-021 ENTER_A, operator key: if operand_valid then op_a<=operand_in, alu_op<=code, iu_clear pulse, ->ENTER_B; else ->ERR.
REQ-022 ENTER_A, equals key: no action; stay.
REQ-023 ENTER_B, operator key: alu_op<=new code, no clear, stay (operator replace).
REQ-024 ENTER_B, equals key: if !operand_valid ->ERR; else if alu_op=div and operand_in=0 ->ERR without alu_start; else op_b<=operand_in, ->EXEC.
REQ-025 EXEC: alu_start=1 for exactly one cycle; ->WAIT next cycle; timeout counter loads 0.
REQ-026 WAIT, alu_done: result<=alu_result; ->ERR if alu_ovf, else ->SHOW.
REQ-027 WAIT: counter increments each cycle without alu_done; at count TIMEOUT-1 with no alu_done ->ERR. alu_done in that same cycle wins.
REQ-028 alu_done outside WAIT is ignored.
REQ-029 SHOW, digit key: iu_clear pulse, ->ENTER_A. Operator key: op_a<=result, alu_op<=code, iu_clear pulse, ->ENTER_B (chaining). Equals key: stay.
REQ-030 ERR: all keys except clear are ignored.
REQ-031 Clear key in any state: iu_clear pulse, result_valid=0, error=0, ->ENTER_A; op_a/op_b/result are retained. Clear takes priority over a simultaneous alu_done or timeout.
REQ-032 Keys other than clear are ignored in EXEC and WAIT.
REQ-033 All outputs are registered; result_valid and error are decoded from the registered state.

Reset
REQ-034 With reset=0 at a clk edge: state=ENTER_A; op_a, op_b, result=0; alu_op=0; alu_start, iu_clear, result_valid, error=0; counter=0.
REQ-035 Reset mid-operation, including in WAIT, abandons the operation; a later alu_done is ignored.

Verification
REQ-036 Operand 12 valid, key 10, operand 5 valid, key 15, ALU returns 17 -> op_a=12, op_b=5, alu_op=0, one alu_start, result=17, result_valid=1.
REQ-037 Operand -3, key 12, operand 4, key 15 (div replaced by mul before equals) -> alu_op=2, result=-12 (0xF4).
REQ-038 Operand 7, key 13, operand 0, key 15 -> no alu_start, error=1; then key 14 -> iu_clear pulse, state=0.
REQ-039 After SHOW with result 17, key 11, operand 20, key 15 -> op_a=17, result=-3; ALU asserts alu_ovf on a later operation -> error=1.
REQ-040 alu_done is withheld -> ERR exactly TIMEOUT cycles after entering WAIT. Reset in WAIT followed by alu_done -> all outputs at reset values.
